bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised multi-digit BCD up/down counter; successor to the single-digit decade counter. Chains DIGITS decade stages with internal carry/borrow ripple, synchronous clear, range-checked parallel load, and registered wrap/load-error status. Used wherever the design needs a decimal event or cycle count, such as cycle/instret display counters or timeout counters with decimal preset.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits (1..8); count width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear to zero
- load  input  1  synchronous parallel load of data_in
- counter_on  input  1  count enable; one step per cycle while high
- count_up  input  1  1 = increment, 0 = decrement
- data_in  input  4*DIGITS  packed BCD load value; digit i at bits [4i+3:4i]
- count  output  4*DIGITS  current packed BCD value
- tc  output  1  combinational terminal count
- wrap  output  1  registered one-cycle pulse after a wrap-around step
- load_err  output  1  registered one-cycle pulse after a load containing a non-BCD digit

## Operation
- Per-edge priority: reset_n low > clear > load > counter_on > hold.
- clear: count <= 0; wrap <= 0; load_err <= 0.
- load: each digit i <= data_in digit i if ≤9, else 9 (clamped). load_err <= 1 if any digit was clamped, else 0. wrap <= 0.
- Count step (counter_on=1, no clear/load):
  - Digit 0 always steps. Digit i>0 steps only when every lower digit is 9 (up) or 0 (down).
  - Up step: digit 9 -> 0, else +1. Down step: digit 0 -> 9, else −1.
  - wrap <= 1 if tc was 1 at this edge (all 9s going up, all 0s going down), else 0.
- Hold (counter_on=0): count unchanged; wrap <= 0; load_err <= 0.
- tc = (count_up & all digits == 9) | (~count_up & all digits == 0); independent of counter_on, load, and clear.
- count_up may change on any cycle. The step direction is the value sampled at that edge.
- Digit values 10–15 can never be held in count.

## Timing
- Reset (reset_n low, asynchronous assert): count = 0, wrap = 0, load_err = 0. tc = 1 if count_up = 0, else 0.
- Deassertion of reset_n is synchronised externally. The first active edge after release acts normally.
- count, wrap, and load_err update one cycle after the qualifying edge. Latency from counter_on to the count change is 1 clk.
- tc follows count and count_up combinationally with zero latency.
- Carry ripple across all digits completes within one cycle. No multi-cycle carry.
- Reset asserted mid-count: outputs go to their reset values immediately. No pending step is retained.
- clear and load together: clear wins. No load_err is produced.
- load and counter_on together: load wins and no step occurs.

## Configuration
- BCD_SATURATE_EN defined: a count step taken while tc=1 leaves count unchanged, so the counter saturates at all-9s going up and all-0s going down. wrap never asserts.
- BCD_SATURATE_EN undefined (default): wrap-around as described in Operation. all-9s +1 -> 0, all-0s −1 -> all-9s, and wrap pulses.

## Test plan
- Reset: reset_n=0 mid-count at 0x0357, count_up=0 -> count=0x0000 immediately. tc=1, wrap=0, load_err=0.
- Up ripple: load 0x0999, then counter_on=1, count_up=1 for 1 cycle -> count=0x1000, tc=0, wrap=0. Load 0x9998, then 2 steps -> 0x9999 (tc=1), then 0x0000 with wrap=1 for exactly one cycle. Under BCD_SATURATE_EN, the count holds at 0x9999 and wrap stays 0.
- Down borrow: load 0x1000, then count_up=0 step -> 0x0999. Load 0x0000, then step -> 0x9999, wrap=1. Under BCD_SATURATE_EN, the count holds at 0x0000.
- Load clamp: data_in=0x3A7F -> count=0x3979, load_err=1 for one cycle. data_in=0x1234 -> count=0x1234, load_err=0.
- Priority: clear=1, load=1, counter_on=1 at count=0x0042 -> count=0x0000. Then load=1, counter_on=1, data_in=0x0500 -> count=0x0500, with no increment.
- Direction flip and hold: at 0x0010, step up -> 0x0011, step down twice -> 0x0009. With counter_on=0 for 5 cycles, count stays 0x0009, and tc toggles with count_up only while count is 0x9999 or 0x0000.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clear, clamped parallel load and wrap/load-error pulses.
// Optional feature: define BCD_SATURATE_EN to saturate at all-9s/all-0s instead of wrapping.
module bcd_digit (
    input  logic [3:0] cur,
    input  logic       up,
    input  logic       step,
    output logic [3:0] nxt,
    output logic       is9,
    output logic       is0
);
    assign is9 = (cur == 4'd9);
    assign is0 = (cur == 4'd0);

    always_comb begin
        nxt = cur;
        if (step) begin
            if (up) nxt = is9 ? 4'd0 : cur + 4'd1;
            else    nxt = is0 ? 4'd9 : cur - 4'd1;
        end
    end
endmodule

module bcd_updown_counter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  counter_on,
    input  logic                  count_up,
    input  logic [4*DIGITS-1:0]   data_in,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);
    logic [4*DIGITS-1:0] count_q, count_d, step_val, ld_val;
    logic                wrap_q, wrap_d, load_err_q, load_err_d;
    logic [DIGITS-1:0]   is9, is0, step_en;
    logic [DIGITS:0]     run9, run0;
    logic                ld_bad, do_step;

    // run9[i]/run0[i]: every digit below i is 9 / 0, i.e. the carry/borrow into digit i
    always_comb begin
        run9[0] = 1'b1;
        run0[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            run9[i+1] = run9[i] & is9[i];
            run0[i+1] = run0[i] & is0[i];
        end
    end

    assign tc = count_up ? run9[DIGITS] : run0[DIGITS];

`ifdef BCD_SATURATE_EN
    assign do_step = counter_on & ~tc;
`else
    assign do_step = counter_on;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign step_en[i] = do_step & (count_up ? run9[i] : run0[i]);
        bcd_digit u_dig (
            .cur  (count_q[4*i +: 4]),
            .up   (count_up),
            .step (step_en[i]),
            .nxt  (step_val[4*i +: 4]),
            .is9  (is9[i]),
            .is0  (is0[i])
        );
    end

    always_comb begin
        ld_val = '0;
        ld_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (data_in[4*i +: 4] > 4'd9) begin
                ld_val[4*i +: 4] = 4'd9;
                ld_bad           = 1'b1;
            end else begin
                ld_val[4*i +: 4] = data_in[4*i +: 4];
            end
        end
    end

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d    = ld_val;
            load_err_d = ld_bad;
        end else if (counter_on) begin
            count_d = step_val;
`ifndef BCD_SATURATE_EN
            wrap_d  = tc;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: a decimal integer model predicts each cycle's outputs.
module tb_bcd_updown_counter;
    localparam int D    = 4;
    localparam int MAXV = 9999;

    typedef struct {
        logic [4*D-1:0] cnt;
        logic           wrap;
        logic           lerr;
        logic           tc;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_n, clear, load, counter_on, count_up;
    logic [4*D-1:0] data_in, count;
    logic           tc, wrap, load_err;

    int   n_chk = 0;
    int   n_err = 0;
    int   mval  = 0;
    exp_t sb_q[$];

    bcd_updown_counter #(.DIGITS(D)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .counter_on(counter_on), .count_up(count_up), .data_in(data_in),
        .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Scoreboard consumer: one expected entry per driven cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("count", 32'(count), 32'(e.cnt));
            chk("wrap", 32'(wrap), 32'(e.wrap));
            chk("load_err", 32'(load_err), 32'(e.lerr));
            chk("tc", 32'(tc), 32'(e.tc));
        end
    end

    task automatic cyc(input logic c, input logic l, input logic on, input logic up,
                       input logic [4*D-1:0] d);
        exp_t e;
        logic tc_pre;
        int   v;
        logic bad;
        @(negedge clk);
        #1;
        clear = c; load = l; counter_on = on; count_up = up; data_in = d;
        e.wrap = 1'b0;
        e.lerr = 1'b0;
        tc_pre = up ? (mval == MAXV) : (mval == 0);
        if (c) begin
            mval = 0;
        end else if (l) begin
            v = 0; bad = 1'b0;
            for (int i = D - 1; i >= 0; i--) begin
                int dg;
                dg = int'(d[4*i +: 4]);
                if (dg > 9) begin dg = 9; bad = 1'b1; end
                v = v * 10 + dg;
            end
            mval   = v;
            e.lerr = bad;
        end else if (on) begin
            if (tc_pre) begin
`ifndef BCD_SATURATE_EN
                mval   = up ? 0 : MAXV;
                e.wrap = 1'b1;
`endif
            end else begin
                mval = up ? mval + 1 : mval - 1;
            end
        end
        e.cnt = to_bcd(mval);
        e.tc  = up ? (mval == MAXV) : (mval == 0);
        sb_q.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        #2;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; load = 1'b0; counter_on = 1'b0;
        count_up = 1'b1; data_in = '0;
        #12;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_tc_up", 32'(tc), 32'd0);
        count_up = 1'b0;
        #1;
        chk("rst_tc_dn", 32'(tc), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Asynchronous reset mid-count
        cyc(0, 1, 0, 0, 16'h0358);
        cyc(0, 0, 1, 0, 16'h0000);
        drain();
        counter_on = 1'b1;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        mval = 0;
        chk("amid_count", 32'(count), 32'h0);
        chk("amid_tc", 32'(tc), 32'd1);
        chk("amid_wrap", 32'(wrap), 32'd0);
        chk("amid_lerr", 32'(load_err), 32'd0);
        @(negedge clk);
        counter_on = 1'b0;
        reset_n = 1'b1;

        // Up ripple and wrap
        cyc(0, 1, 0, 1, 16'h0999);
        cyc(0, 0, 1, 1, 16'h0000);
        cyc(0, 1, 0, 1, 16'h9998);
        cyc(0, 0, 1, 1, 16'h0000);
        cyc(0, 0, 1, 1, 16'h0000);
        cyc(0, 0, 1, 1, 16'h0000);

        // Down borrow and wrap
        cyc(0, 1, 0, 0, 16'h1000);
        cyc(0, 0, 1, 0, 16'h0000);
        cyc(0, 1, 0, 0, 16'h0000);
        cyc(0, 0, 1, 0, 16'h0000);
        cyc(0, 0, 1, 0, 16'h0000);

        // Load clamp
        cyc(0, 1, 0, 1, 16'h3A7F);
        cyc(0, 1, 0, 1, 16'h1234);
        cyc(0, 1, 0, 1, 16'hFFFF);
        cyc(0, 0, 0, 1, 16'h0000);

        // Priority: clear beats load (even a bad one), load beats count
        cyc(0, 1, 0, 1, 16'h0042);
        cyc(1, 1, 1, 1, 16'h3A00);
        cyc(0, 1, 1, 1, 16'h0500);

        // Direction flip and hold
        cyc(0, 1, 0, 1, 16'h0010);
        cyc(0, 0, 1, 1, 16'h0000);
        cyc(0, 0, 1, 0, 16'h0000);
        cyc(0, 0, 1, 0, 16'h0000);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, k[0], 16'h0000);
        cyc(0, 1, 0, 1, 16'h9999);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, k[0], 16'h0000);
        cyc(1, 0, 0, 1, 16'h0000);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, k[0], 16'h0000);

        // Random mix against the model
        for (int k = 0; k < 300; k++) begin
            logic [4*D-1:0] rd;
            int             r;
            rd = 16'($urandom);
            r  = int'($urandom_range(0, 99));
            cyc(r < 3, (r >= 3 && r < 12), r >= 20, 1'($urandom), rd);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
